kernel_map_vecop: RTL and testbench
===================================

# kernel_map_vecop

Parametrised N-lane streaming map node for TyBEC-generated kernels: applies a per-beat selectable binary integer operation lane-wise to two vector streams. The operation result passes through a configurable-depth pipeline with full valid/ready backpressure, so it holds data correctly under downstream stalls. It sits between stream sources/FIFOs and downstream map/reduce nodes wherever a leaf map operation needs vector width, a latency of more than one cycle, or op selection.

## Interface
Parameters:
- STREAMW, 32, bits per lane element
- NLANES, 4, lanes per beat (≥1)
- LAT, 2, pipeline depth in cycles (≥1)
- CNTW, 32, width of output beat counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ivalid  in  1  input beat valid
- iready  out  1  block accepts a beat this cycle
- in1  in  NLANES*STREAMW  operand A; lane i at [i*STREAMW +: STREAMW]
- in2  in  NLANES*STREAMW  operand B, same layout
- op  in  3  operation code, sampled with the beat
- ovalid  out  1  output beat valid (registered)
- oready  in  1  downstream accepts
- out1  out  NLANES*STREAMW  result vector (registered)
- obeats  out  CNTW  count of completed output transfers (registered)

## Operation
- Op codes: 0 add, 1 sub (in1−in2), 2 signed min, 3 signed max, 4 and, 5 or, 6 xor, 7 pass in1.
- Add/sub wrap modulo 2^STREAMW; no carry or overflow output. Min/max compare two's complement.
- Input transfer: ivalid & iready. Output transfer: ovalid & oready.
- Pipeline: LAT stages, each holding data plus one valid bit. Global advance enable en = ~ovalid | oready. iready = en (combinational, no cycle delay).
- When en=1, every stage shifts forward; stage 0 loads the computed result and valid=ivalid. Bubbles (ivalid=0) propagate as invalid stages.
- When en=0, all stages, out1, and ovalid hold.
- out1/ovalid are the last stage. Data in invalid stages is don't-care, but out1 updates only on valid beats when en=1.
- obeats increments by 1 on each output transfer; wraps at 2^CNTW.
- Reset (including mid-stream): all stage valids, ovalid cleared; out1 = 0; obeats = 0. In-flight beats are discarded. iready = 1 in the first cycle after reset.

## Timing
- Latency: a beat accepted at edge k appears with ovalid=1 after edge k+LAT-1 (visible in cycle k+LAT), provided no stall occurs.
- Throughput: 1 beat/cycle with oready held high.
- Stall: ovalid=1 and oready=0 → iready=0 the same cycle; out1 stable until the transfer.
- ovalid=0 → iready=1 regardless of oready (pipeline fills bubbles).
- Simultaneous output transfer and input acceptance in the same cycle is legal and lossless.
- LAT=1: a single register stage; behaviour is identical apart from latency.
- op is registered with its beat's data; an op change between beats affects only the new beat.

## Structure
- Package kernel_map_pkg: op-code localparams (OP_ADD…OP_PASS), op width constant, lane slice helper function.
- Sub-module kernel_map_lane_alu: combinational single-lane op (STREAMW, op, a, b → y), instantiated NLANES times via generate.
- Top module holds the pipeline registers, valid shift chain, enable logic, and counter.

## Test plan
- STREAMW=32, NLANES=4, LAT=2, oready=1; op=0, lanes in1={0xFFFFFFFF,1,2,3}, in2={1,1,1,1} → out1={0,2,3,4} two cycles later; obeats=1.
- op=2 and op=3, in1 lane0=0x80000000, in2 lane0=5 → min=0x80000000, max=5; op=1, 3−5 → 0xFFFFFFFE.
- Stream 8 back-to-back beats, drop oready for 3 cycles mid-stream → iready falls in the same cycle, out1 holds, no beat lost or duplicated, obeats=8 at end, order preserved.
- Alternate ivalid 1/0 with oready=1 → ovalid shows the same 1/0 pattern delayed LAT cycles, with bubbles preserved.
- Assert rst with 2 beats in flight → next cycle ovalid=0, out1=0, obeats=0, iready=1; those beats never appear.
- Repeat the first scenario with LAT=1 and LAT=4 → identical results at latency 1 and 4; CNTW=4 with 17 transfers → obeats=1.

Source files
------------

// File: rtl/kernel_map_pkg.sv
// Shared op codes and lane-slicing helper for the kernel_map streaming nodes.
package kernel_map_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_MIN  = 3'd2;
  localparam logic [OP_W-1:0] OP_MAX  = 3'd3;
  localparam logic [OP_W-1:0] OP_AND  = 3'd4;
  localparam logic [OP_W-1:0] OP_OR   = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  // LSB position of a lane inside a packed lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/kernel_map_lane_alu.sv
// Combinational single-lane binary integer operation.
module kernel_map_lane_alu
  import kernel_map_pkg::*;
#(
  parameter int unsigned STREAMW = 32
) (
  input  logic [OP_W-1:0]    op,
  input  logic [STREAMW-1:0] a,
  input  logic [STREAMW-1:0] b,
  output logic [STREAMW-1:0] y
);

  logic a_lt_b;

  assign a_lt_b = $signed(a) < $signed(b);

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MIN:  y = a_lt_b ? a : b;
      OP_MAX:  y = a_lt_b ? b : a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/kernel_map_vecop.sv
// N-lane streaming map node: lane-wise selectable op followed by a LAT-deep
// pipeline with a single global advance enable for valid/ready backpressure.
module kernel_map_vecop
  import kernel_map_pkg::*;
#(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned NLANES  = 4,
  parameter int unsigned LAT     = 2,
  parameter int unsigned CNTW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ivalid,
  output logic                      iready,
  input  logic [NLANES*STREAMW-1:0] in1,
  input  logic [NLANES*STREAMW-1:0] in2,
  input  logic [OP_W-1:0]           op,
  output logic                      ovalid,
  input  logic                      oready,
  output logic [NLANES*STREAMW-1:0] out1,
  output logic [CNTW-1:0]           obeats
);

  localparam int unsigned VW = NLANES * STREAMW;

  logic [VW-1:0]  res;
  logic [VW-1:0]  data_q [LAT];
  logic [LAT-1:0] valid_q;
  logic [CNTW-1:0] obeats_q;
  logic           en;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    kernel_map_lane_alu #(
      .STREAMW(STREAMW)
    ) u_alu (
      .op(op),
      .a (in1[lane_lsb(i, STREAMW) +: STREAMW]),
      .b (in2[lane_lsb(i, STREAMW) +: STREAMW]),
      .y (res[lane_lsb(i, STREAMW) +: STREAMW])
    );
  end

  // A stage may advance whenever the output slot is empty or being drained.
  assign en     = ~valid_q[LAT-1] | oready;
  assign iready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        data_q[s] <= '0;
      end
    end else if (en) begin
      valid_q[0] <= ivalid;
      if (ivalid) begin
        data_q[0] <= res;
      end
      // Data moves only with valid beats, so out1 keeps the last real result.
      for (int s = 1; s < LAT; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obeats_q <= '0;
    end else if (valid_q[LAT-1] && oready) begin
      obeats_q <= obeats_q + CNTW'(1);
    end
  end

  assign ovalid = valid_q[LAT-1];
  assign out1   = data_q[LAT-1];
  assign obeats = obeats_q;

endmodule

// File: tb/tb_kernel_map_vecop.sv
// Scoreboard bench: three instances (LAT=2/1/4) share one accepted input stream.
module tb_kernel_map_vecop;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ivalid = 1'b0;
  logic [127:0] in1 = '0;
  logic [127:0] in2 = '0;
  logic [2:0]   op = '0;
  logic         oready = 1'b1;
  logic [127:0] exp_cur = '0;

  logic         iready2, ovalid2, iready1, ovalid1, iready4, ovalid4;
  logic [127:0] out2, out1_l1, out4;
  logic [31:0]  obeats2, obeats1;
  logic [3:0]   obeats4;
  logic         ivalid_sec;

  int checks = 0;
  int failures = 0;
  logic [127:0] q2[$];
  logic [127:0] q1[$];
  logic [127:0] q4[$];

  always #5 clk = ~clk;

  assign ivalid_sec = ivalid & iready2;

  kernel_map_vecop #(.STREAMW(32), .NLANES(4), .LAT(2), .CNTW(32)) u_dut2 (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready2), .in1(in1), .in2(in2), .op(op),
    .ovalid(ovalid2), .oready(oready), .out1(out2), .obeats(obeats2)
  );
  kernel_map_vecop #(.STREAMW(32), .NLANES(4), .LAT(1), .CNTW(32)) u_dut1 (
    .clk(clk), .rst(rst), .ivalid(ivalid_sec), .iready(iready1), .in1(in1), .in2(in2), .op(op),
    .ovalid(ovalid1), .oready(1'b1), .out1(out1_l1), .obeats(obeats1)
  );
  kernel_map_vecop #(.STREAMW(32), .NLANES(4), .LAT(4), .CNTW(4)) u_dut4 (
    .clk(clk), .rst(rst), .ivalid(ivalid_sec), .iready(iready4), .in1(in1), .in2(in2), .op(op),
    .ovalid(ovalid4), .oready(1'b1), .out1(out4), .obeats(obeats4)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=unexpected exp=none", name);
  endtask

  // Scoreboard push: one entry per accepted beat for each instance.
  always @(negedge clk) begin
    if (!rst && ivalid && iready2) q2.push_back(exp_cur);
    if (!rst && ivalid_sec && iready1) q1.push_back(exp_cur);
    if (!rst && ivalid_sec && iready4) q4.push_back(exp_cur);
  end

  always @(negedge clk) begin
    if (rst) q2.delete();
    else if (ovalid2 && oready) begin
      if (q2.size() == 0) fail_now("lat2_extra_beat");
      else chk("lat2_out1", out2, q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst) q1.delete();
    else if (ovalid1) begin
      if (q1.size() == 0) fail_now("lat1_extra_beat");
      else chk("lat1_out1", out1_l1, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst) q4.delete();
    else if (ovalid4) begin
      if (q4.size() == 0) fail_now("lat4_extra_beat");
      else chk("lat4_out1", out4, q4.pop_front());
    end
  end

  function automatic logic [127:0] lanes(input int unsigned base, input int unsigned add);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'(base + j + add);
    return v;
  endfunction

  // Holds the beat until the main instance accepts it; returns #1 after that edge.
  task automatic send_beat(input logic [2:0] o, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] e);
    logic acc;
    acc = 1'b0;
    op = o; in1 = a; in2 = b; exp_cur = e; ivalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = iready2;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) fail_now("accept_timeout");
    ivalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ivalid = 1'b0; oready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (q2.size() == 0 && q1.size() == 0 && q4.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", 128'(q2.size() + q1.size() + q4.size()), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first2, first1, first4;
    logic [127:0] held;
    logic [11:0] samp;
    logic [7:0] pat;

    do_reset();
    chk("rst_ovalid", 128'(ovalid2), 128'd0);
    chk("rst_out1", out2, 128'd0);
    chk("rst_obeats", 128'(obeats2), 128'd0);
    chk("rst_iready", 128'(iready2), 128'd1);

    // Add with wrap, plus latency for all three depths.
    send_beat(3'd0, {32'd3, 32'd2, 32'd1, 32'hFFFFFFFF}, {4{32'd1}},
              {32'd4, 32'd3, 32'd2, 32'd0});
    first2 = -1; first1 = -1; first4 = -1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (ovalid2 && first2 < 0) first2 = c;
      if (ovalid1 && first1 < 0) first1 = c;
      if (ovalid4 && first4 < 0) first4 = c;
    end
    chk("lat2_latency", 128'(first2), 128'd1);
    chk("lat1_latency", 128'(first1), 128'd0);
    chk("lat4_latency", 128'(first4), 128'd3);
    chk("obeats_after_first", 128'(obeats2), 128'd1);
    chk("obeats_l1_first", 128'(obeats1), 128'd1);
    chk("obeats_l4_first", 128'(obeats4), 128'd1);

    // Signed min/max, subtract wrap, bitwise and pass.
    send_beat(3'd2, {32'd0, 32'd10, 32'd7, 32'h80000000}, {32'd0, 32'd20, 32'hFFFFFFFF, 32'd5},
              {32'd0, 32'd10, 32'hFFFFFFFF, 32'h80000000});
    send_beat(3'd3, {32'd0, 32'd10, 32'd7, 32'h80000000}, {32'd0, 32'd20, 32'hFFFFFFFF, 32'd5},
              {32'd0, 32'd20, 32'd7, 32'd5});
    send_beat(3'd1, {32'h80000000, 32'd100, 32'd0, 32'd3}, {32'd1, 32'd1, 32'd1, 32'd5},
              {32'h7FFFFFFF, 32'h63, 32'hFFFFFFFF, 32'hFFFFFFFE});
    in1 = {32'hF0F0F0F0, 32'h12345678, 32'hFFFF0000, 32'hAAAAAAAA};
    in2 = {32'hFF00FF00, 32'h0000FFFF, 32'h00FFFF00, 32'h55555555};
    send_beat(3'd4, in1, in2, {32'hF000F000, 32'h00005678, 32'h00FF0000, 32'h00000000});
    send_beat(3'd5, in1, in2, {32'hFFF0FFF0, 32'h1234FFFF, 32'hFFFFFF00, 32'hFFFFFFFF});
    send_beat(3'd6, in1, in2, {32'h0FF00FF0, 32'h1234A987, 32'hFF00FF00, 32'hFFFFFFFF});
    send_beat(3'd7, in1, in2, in1);
    drain();
    chk("obeats_after_ops", 128'(obeats2), 128'd8);

    // Back-to-back stream with a 3-cycle downstream stall.
    do_reset();
    fork
      begin
        for (int b = 0; b < 8; b++) send_beat(3'd0, lanes(b * 16, 0), {4{32'h10}},
                                               lanes(b * 16, 16));
      end
      begin
        repeat (4) @(posedge clk);
        #1 oready = 1'b0;
        #1;
        chk("stall_ovalid", 128'(ovalid2), 128'd1);
        chk("stall_iready", 128'(iready2), 128'd0);
        held = out2;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          #1;
          chk("stall_hold_out1", out2, held);
          chk("stall_hold_iready", 128'(iready2), 128'd0);
        end
        oready = 1'b1;
      end
    join
    drain();
    chk("stream_obeats", 128'(obeats2), 128'd8);

    // Alternating valid: bubbles must reappear LAT cycles later.
    pat = 8'b0101_0101;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      samp[t] = ovalid2;
      if (t < 8) begin
        op = 3'd7; in1 = 128'(t + 100); exp_cur = 128'(t + 100);
        ivalid = pat[t];
      end else begin
        ivalid = 1'b0;
      end
    end
    for (int t = 0; t < 8; t++) chk("bubble_pattern", 128'(samp[t+2]), 128'(pat[t]));
    drain();

    // Reset with two beats in flight; they must never emerge.
    @(posedge clk);
    #1;
    op = 3'd7; in1 = 128'hA; exp_cur = 128'hA; ivalid = 1'b1;
    @(posedge clk);
    #1;
    in1 = 128'hB; exp_cur = 128'hB;
    @(posedge clk);
    #1;
    ivalid = 1'b0; oready = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ovalid", 128'(ovalid2), 128'd0);
    chk("midrst_out1", out2, 128'd0);
    chk("midrst_obeats", 128'(obeats2), 128'd0);
    chk("midrst_iready", 128'(iready2), 128'd1);
    rst = 1'b0; oready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_ghost", 128'(ovalid2 | ovalid4), 128'd0);
    end

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int b = 0; b < 17; b++) send_beat(3'd7, lanes(b, 0), '0, lanes(b, 0));
    drain();
    chk("wrap_obeats_l4", 128'(obeats4), 128'd1);
    chk("count_obeats_l2", 128'(obeats2), 128'd17);
    chk("count_obeats_l1", 128'(obeats1), 128'd17);
    chk("sec_iready", 128'(iready1 & iready4), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
